bc_chain_stage: RTL

Parametrised lane-to-lane broadcast stage for the matmul datapath. It generalises the single-register lane broadcast hop with several additions:
- a valid/ready handshake on both sides;
- a configurable-depth elastic buffer;
- a local tap that lets the lane consume every broadcast element as it passes;
- a programmed element count per broadcast;
- a forward-disable for the last lane;
- a chain-wide invalidate.

One instance sits in each lane. Its input connects to the previous lane's `bc_data_o`, and its output connects to the next lane.

---
 rtl/bc_chain_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bc_chain_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bc_chain_stage                                                  |
// | Purpose  : One lane of the matmul broadcast chain: elastic buffer with a    |
// |            local tap and optional downstream forward, per-broadcast count.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bc_chain_stage #(
    parameter int DataWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    input  logic [CntWidth-1:0]  cfg_len_i,
    input  logic                 cfg_fwd_i,
    output logic                 cfg_ready_o,
    input  logic [DataWidth-1:0] bc_data_i,
    input  logic                 bc_valid_i,
    output logic                 bc_ready_o,
    output logic [DataWidth-1:0] bc_data_o,
    output logic                 bc_valid_o,
    input  logic                 bc_ready_i,
    output logic [DataWidth-1:0] tap_data_o,
    output logic                 tap_valid_o,
    input  logic                 tap_ready_i,
    input  logic                 bc_invalidate_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int c_OCC_W = $clog2(Depth + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(Depth - 1);
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(Depth);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_OCC_W-1:0]   r_count;
    logic [CntWidth-1:0]  r_len;
    logic [CntWidth-1:0]  r_rx_cnt;
    logic [CntWidth-1:0]  r_pop_cnt;
    logic                 r_fwd;
    logic                 r_tap_taken;
    logic                 r_fwd_taken;

    logic                 w_empty;
    logic                 w_start;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tap_fire;
    logic                 w_fwd_fire;
    logic [CntWidth-1:0]  w_pop_cnt_nxt;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_empty       = (r_count == '0);
    assign w_start       = (r_state == S_IDLE) && cfg_valid_i;
    assign w_pop_cnt_nxt = r_pop_cnt + CntWidth'(1);

    // Ready depends only on registered state, so consumer readies never reach it.
    assign bc_ready_o  = (r_state == S_ACTIVE) && (r_count < c_DEPTH) && (r_rx_cnt < r_len);
    assign tap_valid_o = !w_empty && !r_tap_taken;
    assign bc_valid_o  = r_fwd && !w_empty && !r_fwd_taken;
    assign tap_data_o  = r_mem[r_head];
    assign bc_data_o   = r_mem[r_head];

    assign w_push     = bc_valid_i && bc_ready_o;
    assign w_tap_fire = tap_valid_o && tap_ready_i;
    assign w_fwd_fire = bc_valid_o && bc_ready_i;
    assign w_pop      = !w_empty
                     && (r_tap_taken || w_tap_fire)
                     && (!r_fwd || r_fwd_taken || w_fwd_fire);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i) begin
                    w_state_nxt = (cfg_len_i == '0) ? S_DONE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_pop && (w_pop_cnt_nxt == r_len)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bc_invalidate_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_rx_cnt    <= '0;
            r_pop_cnt   <= '0;
            r_fwd       <= 1'b0;
            r_tap_taken <= 1'b0;
            r_fwd_taken <= 1'b0;
        end else if (bc_invalidate_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rx_cnt    <= '0;
            r_pop_cnt   <= '0;
            r_tap_taken <= 1'b0;
            r_fwd_taken <= 1'b0;
        end else begin
            if (w_start) begin
                r_len     <= cfg_len_i;
                r_fwd     <= cfg_fwd_i;
                r_rx_cnt  <= '0;
                r_pop_cnt <= '0;
            end
            if (w_push) begin
                r_mem[r_tail] <= bc_data_i;
                r_tail        <= f_ptr_inc(r_tail);
                r_rx_cnt      <= r_rx_cnt + CntWidth'(1);
            end
            // Taken flags remember a consumer that accepted the head before its partner.
            if (w_pop) begin
                r_head      <= f_ptr_inc(r_head);
                r_pop_cnt   <= w_pop_cnt_nxt;
                r_tap_taken <= 1'b0;
                r_fwd_taken <= 1'b0;
            end else begin
                r_tap_taken <= r_tap_taken || w_tap_fire;
                r_fwd_taken <= r_fwd_taken || w_fwd_fire;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
